vx_addr_bank_dispatch: RTL and testbench
========================================

VX_ADDR_BANK_DISPATCH -- requirements
Module: VX_addr_bank_dispatch

Interface
REQ-001 SHALL have parameter N, default 32: input address width.
REQ-002 SHALL have parameter S, default 2: bank-select bit count; NUM_BANKS = 2^S; S >= 1.
REQ-003 SHALL have parameter POS, default 0: LSB position of the bank-select field; POS + S <= N.
REQ-004 SHALL have parameter TAG_WIDTH, default 8: request tag width.
REQ-005 SHALL have parameter CNT_W, default 32: stall counter width.
REQ-006 SHALL have port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-007 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port req_valid, input, 1: request present.
REQ-009 SHALL have port req_addr, input, N: full request address.
REQ-010 SHALL have port req_tag, input, TAG_WIDTH: request tag.
REQ-011 SHALL have port req_ready, output, 1: request accepted this cycle when high with req_valid.
REQ-012 SHALL have port bank_valid, output, NUM_BANKS: per-bank output valid.
REQ-013 SHALL have port bank_addr, output, NUM_BANKS*(N-S): per-bank stripped address; bank b occupies slice [b*(N-S) +: N-S].
REQ-014 SHALL have port bank_tag, output, NUM_BANKS*TAG_WIDTH: per-bank tag, packed the same way.
REQ-015 SHALL have port bank_ready, input, NUM_BANKS: per-bank consumer ready.
REQ-016 SHALL have port stall_count, output, CNT_W: count of cycles where req_valid=1 and req_ready=0.

Function
REQ-017 SHALL decode the bank index as req_addr[POS+S-1:POS].
REQ-018 SHALL form the stripped address by removing those S bits, so that req_addr bits above the field move down by S and bits below the field keep their positions.
- Result width is N-S.
- POS=0 and POS=N-S are legal.
REQ-019 SHALL provide one 2-entry FIFO per bank holding {stripped address, tag}.
REQ-020 SHALL drive req_ready = NOT full[bank index], whatever the value of req_valid.
- A full FIFO SHALL deassert req_ready even if it is dequeuing in the same cycle.
- req_ready SHALL have no combinational path from bank_ready.
REQ-021 SHALL enqueue to the decoded bank's FIFO exactly when req_valid AND req_ready; no other FIFO changes because of that request.
REQ-022 SHALL drive bank_valid[b] = NOT empty[b].
- bank_addr/bank_tag slice b SHALL show the FIFO head, registered, with no combinational path from req_*.
- Minimum latency: a request accepted at edge t appears at bank_valid in the cycle after edge t.
REQ-023 SHALL dequeue FIFO b exactly when bank_valid[b] AND bank_ready[b].
REQ-024 SHALL apply enqueue and dequeue on the same FIFO in the same cycle together.
- Occupancy stays unchanged and FIFO order is preserved.
- From empty, a simultaneous enqueue/dequeue cannot occur, because bank_valid is 0.
REQ-025 SHALL preserve per-bank order; no ordering is guaranteed across banks.
REQ-026 SHALL block in-order: a stalled request blocks all later requests, including those to other banks, until it is accepted.
REQ-027 SHALL increment stall_count by 1 on each cycle where req_valid=1 and req_ready=0, saturating at 2^CNT_W-1.
REQ-028 SHALL let data outputs of empty banks hold stale values; those values carry no meaning while bank_valid[b]=0.

Reset
REQ-029 SHALL, while reset=1 at an edge:
- empty all FIFOs, so bank_valid=0 from the next cycle;
- clear stall_count to 0;
- discard in-flight entries.
REQ-030 SHALL hold req_ready=1 after reset (all FIFOs empty).
REQ-031 SHALL clear bank_addr/bank_tag to 0 on reset.
REQ-032 SHALL accept and count nothing in a cycle where reset=1.

Verification (N=8, S=2, POS=2, TAG_WIDTH=4, CNT_W=4 unless noted)
REQ-033 SHALL cover basic routing: req_addr=0xB6, tag=0x5, bank_ready all 1 -> next cycle bank_valid=4'b0010, bank 1 addr=6'h2E, tag=0x5; idle one cycle later.
REQ-034 SHALL cover full/backpressure: bank_ready[0]=0, send 0x00, 0x01, 0x02 back-to-back -> first two accepted, req_ready=0 on the third, stall_count increments each cycle to 3 over 3 stalled cycles; raise bank_ready[0] -> outputs 6'h00, 6'h01, 6'h02 in order, third accepted the cycle after the first dequeue.
REQ-035 SHALL cover simultaneous enqueue/dequeue: bank 3 holds 1 entry, bank_ready[3]=1, new request 0xFC -> occupancy stays 1 and the head advances to 6'h3C next cycle.
REQ-036 SHALL cover head-of-line blocking: bank 0 full and stalled, request to bank 0 then bank 2 queued -> bank_valid[2] stays 0 until bank 0 drains.
REQ-037 SHALL cover reset mid-operation: 2 banks holding entries, stall_count=5, assert reset 1 cycle -> next cycle bank_valid=0, stall_count=0, req_ready=1.
REQ-038 SHALL cover saturation and field edges: 20 stall cycles -> stall_count holds at 15; POS=0 with 0xB6 -> bank 2, addr 6'h2D; POS=6 with 0xB6 -> bank 2, addr 6'h36.

Source files
------------

// File: rtl/vx_addr_bank_dispatch.sv
// Address-interleaved request dispatcher: routes each request to a bank selected by an
// address field, stripping that field, through a 2-entry FIFO per bank.
module vx_addr_bank_dispatch #(
    parameter int N         = 32,
    parameter int S         = 2,
    parameter int POS       = 0,
    parameter int TAG_WIDTH = 8,
    parameter int CNT_W     = 32,
    localparam int NUM_BANKS = 2 ** S,
    localparam int AW        = N - S
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           req_valid,
    input  logic [N-1:0]                   req_addr,
    input  logic [TAG_WIDTH-1:0]           req_tag,
    output logic                           req_ready,
    output logic [NUM_BANKS-1:0]           bank_valid,
    output logic [NUM_BANKS*AW-1:0]        bank_addr,
    output logic [NUM_BANKS*TAG_WIDTH-1:0] bank_tag,
    input  logic [NUM_BANKS-1:0]           bank_ready,
    output logic [CNT_W-1:0]               stall_count
);

    localparam int EW = AW + TAG_WIDTH;

    logic [S-1:0]         bank_idx;
    logic [AW-1:0]        strip_addr;
    logic [NUM_BANKS-1:0] bank_sel;
    logic [NUM_BANKS-1:0] full;
    logic                 accept;
    logic [EW-1:0]        entry;

    assign bank_idx = req_addr[POS +: S];

    // Bits below the select field stay put; bits above it shift down by S.
    always_comb begin
        strip_addr = '0;
        for (int i = 0; i < AW; i++) begin
            strip_addr[i] = (i < POS) ? req_addr[i] : req_addr[i + S];
        end
    end

    assign bank_sel  = NUM_BANKS'(1) << bank_idx;
    assign req_ready = ~full[bank_idx];
    assign accept    = req_valid & req_ready;
    assign entry     = {strip_addr, req_tag};

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [EW-1:0] mem0;
        logic [EW-1:0] mem1;
        logic [EW-1:0] head;
        logic          rd_ptr;
        logic          wr_ptr;
        logic [1:0]    count;
        logic          enq;
        logic          deq;

        assign enq           = accept & bank_sel[b];
        assign deq           = (count != 2'd0) & bank_ready[b];
        assign full[b]       = count[1];
        assign bank_valid[b] = (count != 2'd0);
        assign head          = rd_ptr ? mem1 : mem0;

        assign bank_addr[b*AW +: AW]              = head[EW-1:TAG_WIDTH];
        assign bank_tag[b*TAG_WIDTH +: TAG_WIDTH] = head[TAG_WIDTH-1:0];

        always_ff @(posedge clk) begin
            if (reset) begin
                mem0   <= '0;
                mem1   <= '0;
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
                count  <= 2'd0;
            end else begin
                if (enq) begin
                    if (wr_ptr) mem1 <= entry;
                    else        mem0 <= entry;
                    wr_ptr <= ~wr_ptr;
                end
                if (deq) rd_ptr <= ~rd_ptr;
                case ({enq, deq})
                    2'b10:   count <= count + 2'd1;
                    2'b01:   count <= count - 2'd1;
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
        end else if (req_valid && !req_ready && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_vx_addr_bank_dispatch.sv
// Directed bench for vx_addr_bank_dispatch: routing, backpressure, in-order blocking,
// reset and saturation, plus field-position edge cases on two extra instances.
module tb_vx_addr_bank_dispatch;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic [7:0]  req_addr;
    logic [3:0]  req_tag;
    logic        req_ready;
    logic [3:0]  bank_valid;
    logic [23:0] bank_addr;
    logic [15:0] bank_tag;
    logic [3:0]  bank_ready;
    logic [3:0]  stall_count;

    logic [3:0]  all_ready;
    logic        v0_req_ready, v6_req_ready;
    logic [3:0]  v0_bank_valid, v6_bank_valid;
    logic [23:0] v0_bank_addr, v6_bank_addr;
    logic [15:0] v0_bank_tag, v6_bank_tag;
    logic [3:0]  v0_stall_count, v6_stall_count;

    int n_checks = 0;
    int n_errors = 0;

    vx_addr_bank_dispatch #(.N(8), .S(2), .POS(2), .TAG_WIDTH(4), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_tag(req_tag), .req_ready(req_ready), .bank_valid(bank_valid),
        .bank_addr(bank_addr), .bank_tag(bank_tag), .bank_ready(bank_ready),
        .stall_count(stall_count)
    );

    vx_addr_bank_dispatch #(.N(8), .S(2), .POS(0), .TAG_WIDTH(4), .CNT_W(4)) dut_pos0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_tag(req_tag), .req_ready(v0_req_ready), .bank_valid(v0_bank_valid),
        .bank_addr(v0_bank_addr), .bank_tag(v0_bank_tag), .bank_ready(all_ready),
        .stall_count(v0_stall_count)
    );

    vx_addr_bank_dispatch #(.N(8), .S(2), .POS(6), .TAG_WIDTH(4), .CNT_W(4)) dut_pos6 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_tag(req_tag), .req_ready(v6_req_ready), .bank_valid(v6_bank_valid),
        .bank_addr(v6_bank_addr), .bank_tag(v6_bank_tag), .bank_ready(all_ready),
        .stall_count(v6_stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        all_ready  = 4'hF;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_addr   = 8'h00;
        req_tag    = 4'h0;
        bank_ready = 4'hF;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        sample();
        chk("rst_valid", 32'(bank_valid), 32'h0);
        chk("rst_ready", 32'(req_ready), 32'h1);
        chk("rst_stall", 32'(stall_count), 32'h0);
        chk("rst_addr", 32'(bank_addr), 32'h0);
        chk("rst_tag", 32'(bank_tag), 32'h0);

        // basic routing 0xB6 on all three field positions
        tick();
        req_valid = 1'b1; req_addr = 8'hB6; req_tag = 4'h5;
        sample();
        chk("route_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = 1'b0;
        sample();
        chk("route_valid", 32'(bank_valid), 32'h2);
        chk("route_addr", 32'(bank_addr[6 +: 6]), 32'h2E);
        chk("route_tag", 32'(bank_tag[4 +: 4]), 32'h5);
        chk("pos0_valid", 32'(v0_bank_valid), 32'h4);
        chk("pos0_addr", 32'(v0_bank_addr[12 +: 6]), 32'h2D);
        chk("pos6_valid", 32'(v6_bank_valid), 32'h4);
        chk("pos6_addr", 32'(v6_bank_addr[12 +: 6]), 32'h36);
        chk("pos6_tag", 32'(v6_bank_tag[8 +: 4]), 32'h5);
        tick();
        sample();
        chk("route_idle", 32'(bank_valid), 32'h0);
        chk("pos0_idle", 32'(v0_bank_valid), 32'h0);

        // full FIFO and backpressure on bank 0
        tick();
        bank_ready = 4'b1110;
        req_valid = 1'b1; req_addr = 8'h00; req_tag = 4'h1;
        tick();
        req_addr = 8'h01; req_tag = 4'h2;
        tick();
        req_addr = 8'h02; req_tag = 4'h3;
        sample();
        chk("bp_ready_full", 32'(req_ready), 32'h0);
        chk("bp_valid", 32'(bank_valid), 32'h1);
        chk("bp_head0", 32'(bank_addr[0 +: 6]), 32'h00);
        chk("bp_tag0", 32'(bank_tag[0 +: 4]), 32'h1);
        tick();
        sample();
        chk("bp_stall1", 32'(stall_count), 32'h1);
        tick();
        bank_ready = 4'hF;
        sample();
        chk("bp_stall2", 32'(stall_count), 32'h2);
        chk("bp_full_deq_ready", 32'(req_ready), 32'h0);
        tick();
        sample();
        chk("bp_stall3", 32'(stall_count), 32'h3);
        chk("bp_head1", 32'(bank_addr[0 +: 6]), 32'h01);
        chk("bp_ready_again", 32'(req_ready), 32'h1);
        tick();
        req_valid = 1'b0;
        sample();
        chk("bp_head2", 32'(bank_addr[0 +: 6]), 32'h02);
        chk("bp_tag2", 32'(bank_tag[0 +: 4]), 32'h3);
        chk("bp_stall_hold", 32'(stall_count), 32'h3);
        chk("bp_valid2", 32'(bank_valid), 32'h1);
        tick();
        sample();
        chk("bp_drained", 32'(bank_valid), 32'h0);

        // simultaneous enqueue/dequeue on bank 3
        tick();
        bank_ready = 4'b0111;
        req_valid = 1'b1; req_addr = 8'h0C; req_tag = 4'h6;
        tick();
        bank_ready = 4'hF;
        req_addr = 8'hFC; req_tag = 4'h7;
        sample();
        chk("sim_valid_a", 32'(bank_valid), 32'h8);
        chk("sim_head_a", 32'(bank_addr[18 +: 6]), 32'h00);
        chk("sim_tag_a", 32'(bank_tag[12 +: 4]), 32'h6);
        tick();
        req_valid = 1'b0;
        sample();
        chk("sim_valid_b", 32'(bank_valid), 32'h8);
        chk("sim_head_b", 32'(bank_addr[18 +: 6]), 32'h3C);
        chk("sim_tag_b", 32'(bank_tag[12 +: 4]), 32'h7);
        tick();
        sample();
        chk("sim_occ1", 32'(bank_valid), 32'h0);

        // head-of-line blocking: bank 0 full, bank 2 request waits behind it
        tick();
        bank_ready = 4'b1110;
        req_valid = 1'b1; req_addr = 8'h10; req_tag = 4'h1;
        tick();
        req_addr = 8'h20; req_tag = 4'h2;
        tick();
        req_addr = 8'h30; req_tag = 4'h3;
        sample();
        chk("hol_ready", 32'(req_ready), 32'h0);
        chk("hol_valid_a", 32'(bank_valid), 32'h1);
        tick();
        bank_ready = 4'hF;
        sample();
        chk("hol_stall4", 32'(stall_count), 32'h4);
        chk("hol_b2_idle", 32'(bank_valid[2]), 32'h0);
        tick();
        sample();
        chk("hol_stall5", 32'(stall_count), 32'h5);
        chk("hol_head", 32'(bank_addr[0 +: 6]), 32'h08);
        chk("hol_valid_b", 32'(bank_valid), 32'h1);
        tick();
        req_addr = 8'h4B; req_tag = 4'h9;
        sample();
        chk("hol_valid_c", 32'(bank_valid), 32'h1);
        chk("hol_head_c", 32'(bank_addr[0 +: 6]), 32'h0C);
        tick();
        bank_ready = 4'h0;
        req_addr = 8'hB6; req_tag = 4'hA;
        sample();
        chk("hol_b2_out", 32'(bank_valid), 32'h4);
        chk("hol_b2_addr", 32'(bank_addr[12 +: 6]), 32'h13);
        chk("hol_b2_tag", 32'(bank_tag[8 +: 4]), 32'h9);

        // reset mid-operation with a request pending
        tick();
        req_addr = 8'hFC; req_tag = 4'hB;
        tick();
        reset = 1'b1;
        req_addr = 8'h00; req_tag = 4'hC;
        sample();
        chk("mid_valid", 32'(bank_valid), 32'hE);
        chk("mid_stall", 32'(stall_count), 32'h5);
        tick();
        reset = 1'b0;
        req_valid = 1'b0;
        bank_ready = 4'hF;
        sample();
        chk("rst2_valid", 32'(bank_valid), 32'h0);
        chk("rst2_stall", 32'(stall_count), 32'h0);
        chk("rst2_ready", 32'(req_ready), 32'h1);
        chk("rst2_addr", 32'(bank_addr), 32'h0);
        chk("rst2_tag", 32'(bank_tag), 32'h0);

        // stall counter saturation
        tick();
        bank_ready = 4'b1110;
        req_valid = 1'b1; req_addr = 8'h00; req_tag = 4'h1;
        tick();
        tick();
        sample();
        chk("sat_start", 32'(stall_count), 32'h0);
        chk("sat_ready", 32'(req_ready), 32'h0);
        repeat (10) tick();
        sample();
        chk("sat_mid", 32'(stall_count), 32'hA);
        repeat (10) tick();
        sample();
        chk("sat_top", 32'(stall_count), 32'hF);
        tick();
        req_valid = 1'b0;
        sample();
        chk("sat_hold", 32'(stall_count), 32'hF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
